// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and types for the instruction memory and its loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package inst_mem_loader_pkg;

  // Instruction memory geometry, shared with the instruction memory itself.
  localparam int IMEM_BYTES = 16;
  localparam int ADDR_BITS  = 64;
  localparam int WORD_BITS  = 32;
  localparam int BYTE_BITS  = 8;
  localparam int WORD_BYTES = WORD_BITS / BYTE_BITS;

  // Loader FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_WRITE     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // A load request is legal when:
  //   - the base is word aligned;
  //   - the word count is in 1..max_words;
  //   - the last byte fits inside the memory.
  // The end address is formed one bit wider than an address, so a base
  // near 2^64 cannot wrap around and pass the bound check.
  function automatic logic start_ok(
    input logic [ADDR_BITS-1:0] base,
    input logic [2:0]           nw,
    input int unsigned          mem_bytes,
    input int unsigned          max_words
  );
    logic [ADDR_BITS:0] end_addr;
    end_addr = {1'b0, base} + (ADDR_BITS+1)'({nw, 2'b00});
    return (base[1:0] == 2'b00) &&
           (nw != 3'd0) &&
           (32'(nw) <= max_words) &&
           (end_addr <= (ADDR_BITS+1)'(mem_bytes));
  endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, little-endian.
// Latency: word accepted in cycle N is written as bytes in N+1..N+4; next word accepted in N+5.
// Backpressure: word_ready is high only while waiting for a word; abort and reset win over any handshake.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int MAX_WORDS = IMEM_BYTES / WORD_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [2:0]           num_words,
  input  logic [WORD_BITS-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic                 abort,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [BYTE_BITS-1:0] mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  state_t               state_q;
  state_t               state_d;
  logic [ADDR_BITS-1:0] cur_addr_q;
  logic [2:0]           words_left_q;
  logic [1:0]           byte_idx_q;
  logic [WORD_BITS-1:0] word_q;
  logic                 error_q;

  logic                 start_accept;
  logic                 start_reject;
  logic                 word_take;

  // State register; reset always lands in IDLE regardless of other inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake decode and memory port drive.
  always_comb begin
    state_d      = state_q;
    word_ready   = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = (state_q != ST_IDLE);
    done         = 1'b0;
    start_accept = 1'b0;
    start_reject = 1'b0;
    word_take    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Abort has no meaning while idle.
        if (start) begin
          if (start_ok(base_addr, num_words, int'(unsigned'(MEM_BYTES)), int'(unsigned'(MAX_WORDS)))) begin
            start_accept = 1'b1;
            state_d      = ST_WAIT_WORD;
          end else begin
            start_reject = 1'b1;
          end
        end
      end

      ST_WAIT_WORD: begin
        // Ready stays visible even when abort discards the handshake.
        word_ready = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (word_valid) begin
          word_take = 1'b1;
          state_d   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // The current byte still goes out on an abort cycle.
        mem_we    = 1'b1;
        mem_addr  = cur_addr_q + ADDR_BITS'(byte_idx_q);
        mem_wdata = word_q[{byte_idx_q, 3'b000} +: BYTE_BITS];
        if (abort) begin
          state_d = ST_IDLE;
        end else if (byte_idx_q == 2'd3) begin
          state_d = (words_left_q == 3'd1) ? ST_DONE : ST_WAIT_WORD;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // While reset is held, every output reads as idle and nothing is decoded.
    if (reset) begin
      state_d      = ST_IDLE;
      word_ready   = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      busy         = 1'b0;
      done         = 1'b0;
      start_accept = 1'b0;
      start_reject = 1'b0;
      word_take    = 1'b0;
    end
  end

  // Load context: address cursor, remaining words, byte index, captured word and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr_q   <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      error_q      <= 1'b0;
    end else begin
      error_q <= start_reject;

      if (start_accept) begin
        cur_addr_q   <= base_addr;
        words_left_q <= num_words;
        byte_idx_q   <= '0;
      end

      if (word_take) begin
        word_q     <= word_in;
        byte_idx_q <= '0;
      end

      if (state_q == ST_WRITE) begin
        if (abort) begin
          // Bytes already written stay in memory; only the cursor is dropped.
          byte_idx_q <= '0;
        end else begin
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            cur_addr_q   <= cur_addr_q + ADDR_BITS'(WORD_BYTES);
            words_left_q <= words_left_q - 3'd1;
          end
        end
      end
    end
  end

  assign error = error_q & ~reset;

endmodule
